// File: rtl/cpu_sys_pio_pkg.sv
// Shared constants for the cpu_sys PIO slave and its arbiter.
package cpu_sys_pio_pkg;

  localparam int unsigned PIO_AW = 3;
  localparam int unsigned PIO_DW = 32;

  // PIO register offsets.
  localparam logic [PIO_AW-1:0] PIO_DATA     = 3'd0;
  localparam logic [PIO_AW-1:0] PIO_EDGE_CAP = 3'd3;
  localparam logic [PIO_AW-1:0] PIO_OUTSET   = 3'd4;
  localparam logic [PIO_AW-1:0] PIO_OUTCLR   = 3'd5;

  typedef logic [PIO_AW-1:0] pio_addr_t;
  typedef logic [PIO_DW-1:0] pio_data_t;

endpackage

// File: rtl/cpu_sys_pio_arb_if.sv
// Requester-side and PIO-side Avalon-MM signals of the PIO arbiter.
// slave: arbiter view; master: requesters plus PIO slave view.
interface cpu_sys_pio_arb_if
  import cpu_sys_pio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [PIO_AW*NUM_REQ-1:0] req_address;
  logic [PIO_DW*NUM_REQ-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  pio_data_t                 req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  pio_addr_t                 pio_address;
  logic                      pio_chipselect;
  logic                      pio_write_n;
  pio_data_t                 pio_writedata;
  pio_data_t                 pio_readdata;

  modport slave (
    input  req_read, req_write, req_address, req_writedata, pio_readdata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  modport master (
    output req_read, req_write, req_address, req_writedata, pio_readdata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

endinterface

// File: rtl/cpu_sys_rr_pick.sv
// Combinational round-robin picker: first active index after last_i, wrapping.
module cpu_sys_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] active_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);

  // Scan from last_i+1 around to last_i itself; the first active hit wins.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    valid_o = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      int unsigned idx;
      idx = (32'(last_i) + off) % NUM_REQ;
      if (!valid_o && active_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_sys_pio_arb.sv
// Round-robin arbiter sharing one PIO Avalon-MM slave between NUM_REQ requesters.
// Commands pass straight through in the grant cycle; read responses are routed
// back one cycle later through a single-entry owner pipeline.
module cpu_sys_pio_arb
  import cpu_sys_pio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_sys_pio_arb_if.slave  bus
);

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic               acc_rd;

  logic [ID_W-1:0]    last_d, last_q;
  logic               rd_vld_d, rd_vld_q;
  logic [ID_W-1:0]    rd_id_d, rd_id_q;

  // Both strobes set counts as a write, so active is just the OR.
  always_comb begin
    active = bus.req_read | bus.req_write;
  end

  cpu_sys_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .active_i (active),
    .last_i   (last_q),
    .grant_o  (grant),
    .id_o     (gnt_id),
    .valid_o  (gnt_vld)
  );

  // Drive the slave from the granted requester; idle values when nobody is granted.
  always_comb begin
    bus.req_waitrequest = active & ~grant;
    bus.pio_chipselect  = 1'b0;
    bus.pio_write_n     = 1'b1;
    bus.pio_address     = '0;
    bus.pio_writedata   = '0;
    acc_rd              = 1'b0;
    if (gnt_vld) begin
      bus.pio_chipselect = 1'b1;
      bus.pio_write_n    = ~bus.req_write[gnt_id];
      bus.pio_address    = bus.req_address[gnt_id*PIO_AW +: PIO_AW];
      bus.pio_writedata  = bus.req_writedata[gnt_id*PIO_DW +: PIO_DW];
      acc_rd             = bus.req_read[gnt_id] & ~bus.req_write[gnt_id];
    end
  end

  // Next-state for the round-robin pointer and the read-owner pipeline.
  always_comb begin
    last_d   = gnt_vld ? gnt_id : last_q;
    rd_vld_d = acc_rd;
    rd_id_d  = acc_rd ? gnt_id : rd_id_q;
  end

  // State; reset puts last at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= ID_W'(NUM_REQ - 1);
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
    end else begin
      last_q   <= last_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

  // Response routing: readdata is broadcast, valid is one-hot to the owner.
  always_comb begin
    bus.req_readdata = bus.pio_readdata;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_readdatavalid[i] = rd_vld_q && (rd_id_q == ID_W'(i));
    end
  end

endmodule

// File: tb/tb_cpu_sys_pio_arb.sv
// Scoreboard bench for cpu_sys_pio_arb with two requesters and a PIO slave model.
module tb_cpu_sys_pio_arb;
  import cpu_sys_pio_pkg::*;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  waitreq;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
  } acc_t;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  rdv;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] out_reg = '0;

  acc_t acc_q[$];
  rd_t  rd_q[$];

  cpu_sys_pio_arb_if #(.NUM_REQ(2)) bus ();

  cpu_sys_pio_arb #(.NUM_REQ(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pio_rd_val(input logic [2:0] a);
    case (a)
      PIO_DATA:     return 32'hA5A5_0001;
      PIO_EDGE_CAP: return 32'hEC00_0003;
      default:      return 32'hDEAD_0000 | {29'd0, a};
    endcase
  endfunction

  // PIO slave model: registered readdata, OUTSET/OUTCLR on the output register.
  always @(posedge clk) begin
    if (bus.pio_chipselect && bus.pio_write_n) bus.pio_readdata <= pio_rd_val(bus.pio_address);
    if (bus.pio_chipselect && !bus.pio_write_n) begin
      if (bus.pio_address == PIO_OUTSET) out_reg <= out_reg | bus.pio_writedata;
      if (bus.pio_address == PIO_OUTCLR) out_reg <= out_reg & ~bus.pio_writedata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, match slave accesses and read responses against the queues.
  always @(negedge clk) begin
    acc_t ea;
    rd_t  er;
    acc_t aa;
    rd_t  ar;
    aa = '{cyc, bus.req_waitrequest, bus.pio_write_n, bus.pio_address, bus.pio_writedata};
    ar = '{cyc, bus.req_readdatavalid, bus.req_readdata};
    if (bus.pio_chipselect) begin
      if (acc_q.size() != 0 && acc_q[0].cyc == cyc) begin
        ea = acc_q.pop_front();
        chk("access", 64'(aa), 64'(ea));
      end else begin
        chk("unexpected_access", 64'(aa), 64'd0);
      end
    end else if (acc_q.size() != 0 && acc_q[0].cyc <= cyc) begin
      ea = acc_q.pop_front();
      chk("missing_access", 64'd0, 64'(ea));
    end
    if (bus.req_readdatavalid != 2'b00) begin
      if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
        er = rd_q.pop_front();
        chk("readresp", 64'(ar), 64'(er));
      end else begin
        chk("unexpected_readresp", 64'(ar), 64'd0);
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      er = rd_q.pop_front();
      chk("missing_readresp", 64'(ar), 64'(er));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] d);
    bus.req_read[i]             = rd;
    bus.req_write[i]            = wr;
    bus.req_address[i*3 +: 3]   = a;
    bus.req_writedata[i*32 +: 32] = d;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic exp_acc(input logic [1:0] w, input logic wn, input logic [2:0] a,
                         input logic [31:0] d);
    acc_q.push_back('{cyc, w, wn, a, d});
  endtask

  task automatic exp_rd(input logic [1:0] v, input logic [31:0] d);
    rd_q.push_back('{cyc + 1, v, d});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"},   64'(bus.pio_chipselect), 64'd0);
    chk({tag, "_wn"},   64'(bus.pio_write_n), 64'd1);
    chk({tag, "_addr"}, 64'(bus.pio_address), 64'd0);
    chk({tag, "_wd"},   64'(bus.pio_writedata), 64'd0);
    chk({tag, "_rdv"},  64'(bus.req_readdatavalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    chk_reset_outputs("reset");
    chk("reset_wait", 64'(bus.req_waitrequest), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Contention from reset: req0 first, req1 held off one cycle.
    set_req(0, 1'b0, 1'b1, PIO_DATA, 32'h11);
    set_req(1, 1'b0, 1'b1, PIO_DATA, 32'h22);
    exp_acc(2'b10, 1'b0, PIO_DATA, 32'h11);
    step();
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0);
    exp_acc(2'b00, 1'b0, PIO_DATA, 32'h22);
    step();
    idle();
    step();

    // Single read from req0.
    set_req(0, 1'b1, 1'b0, PIO_DATA, 32'd0);
    exp_acc(2'b00, 1'b1, PIO_DATA, 32'd0);
    exp_rd(2'b01, 32'hA5A5_0001);
    step();
    idle();
    step();

    // Pipelined: req1 OUTCLR write, req0 read the next cycle.
    set_req(1, 1'b0, 1'b1, PIO_OUTCLR, 32'hF0);
    exp_acc(2'b00, 1'b0, PIO_OUTCLR, 32'hF0);
    step();
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0);
    set_req(0, 1'b1, 1'b0, PIO_DATA, 32'd0);
    exp_acc(2'b00, 1'b1, PIO_DATA, 32'd0);
    exp_rd(2'b01, 32'hA5A5_0001);
    step();
    idle();
    step();

    // Read+write collision on req1 is a write to OUTSET, no response.
    set_req(1, 1'b1, 1'b1, PIO_OUTSET, 32'h0F);
    exp_acc(2'b00, 1'b0, PIO_OUTSET, 32'h0F);
    step();
    idle();
    step();
    chk("outset_applied", 64'(out_reg), 64'h0F);

    // Sustained read contention on EDGE_CAP: grants alternate 0,1,...
    set_req(0, 1'b1, 1'b0, PIO_EDGE_CAP, 32'h1000);
    set_req(1, 1'b1, 1'b0, PIO_EDGE_CAP, 32'h2000);
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        exp_acc(2'b10, 1'b1, PIO_EDGE_CAP, 32'h1000);
        exp_rd(2'b01, 32'hEC00_0003);
      end else begin
        exp_acc(2'b01, 1'b1, PIO_EDGE_CAP, 32'h2000);
        exp_rd(2'b10, 32'hEC00_0003);
      end
      step();
    end
    idle();
    step();
    step();

    // Reset mid-read: response dropped, pointer back to requester 0.
    set_req(0, 1'b1, 1'b0, PIO_DATA, 32'd0);
    exp_acc(2'b00, 1'b1, PIO_DATA, 32'd0);
    step();
    reset_n = 1'b0;
    idle();
    #1;
    chk_reset_outputs("midreset");
    step();
    reset_n = 1'b1;
    step();
    set_req(0, 1'b0, 1'b1, PIO_DATA, 32'h33);
    set_req(1, 1'b0, 1'b1, PIO_DATA, 32'h44);
    exp_acc(2'b10, 1'b0, PIO_DATA, 32'h33);
    step();
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0);
    exp_acc(2'b00, 1'b0, PIO_DATA, 32'h44);
    step();
    idle();
    step();
    step();

    chk("acc_queue_drained", 64'(acc_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
